// File: rtl/comb_scan_ctrl.sv
// comb_scan_ctrl: walks every input vector of a combinational block and captures its truth table; COMB_SCAN_CMP_EN adds compare against EXPECT
module comb_scan_ctrl #(
  parameter int N_IN       = 3,
  parameter int SETTLE_CYC = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic                 Y_IN,
  input  logic [2**N_IN-1:0]   EXPECT,
  output logic [N_IN-1:0]      VEC,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [2**N_IN-1:0]   TT,
  output logic                 MISMATCH,
  output logic [N_IN:0]        ERR_CNT
);
  localparam int NV = 2**N_IN;
  localparam int CW = N_IN + 1;
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FIN} state_t;
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [N_IN-1:0] vec_nx;
  logic [NV-1:0] tt_nx;
  logic start_acc;
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    vec_nx    = VEC;
    tt_nx     = TT;
    start_acc = 1'b0;
    case (state)
      IDLE: if (START && !ABORT) begin
        state_nx  = DRIVE;
        cnt_nx    = '0;
        vec_nx    = '0;
        tt_nx     = '0;
        start_acc = 1'b1;
      end
      DRIVE: begin
        state_nx = ABORT ? IDLE : (cnt == 4'(SETTLE_CYC - 1)) ? SAMPLE : DRIVE;
        cnt_nx   = (ABORT || cnt == 4'(SETTLE_CYC - 1)) ? 4'd0 : cnt + 4'd1;
        vec_nx   = ABORT ? '0 : VEC;
      end
      SAMPLE: if (ABORT) begin
        state_nx = IDLE;
        vec_nx   = '0;
      end else begin
        tt_nx[VEC] = Y_IN;
        state_nx   = (VEC == {N_IN{1'b1}}) ? FIN : DRIVE;
        vec_nx     = (VEC == {N_IN{1'b1}}) ? VEC : VEC + N_IN'(1);
        cnt_nx     = '0;
      end
      default: begin
        state_nx = IDLE;
        vec_nx   = '0;
      end
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      VEC   <= '0;
      TT    <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      VEC   <= vec_nx;
      TT    <= tt_nx;
    end
  end
  assign BUSY = (state != IDLE);
  assign DONE = (state == FIN);
`ifdef COMB_SCAN_CMP_EN
  // compare against the table including the final sample, so results line up with DONE
  logic [CW-1:0] pop;
  always_comb begin
    pop = '0;
    for (int i = 0; i < NV; i++) pop = pop + CW'(tt_nx[i] ^ EXPECT[i]);
  end
  always_ff @(posedge CLK) begin
    if (RST || start_acc) begin
      MISMATCH <= 1'b0;
      ERR_CNT  <= '0;
    end else if (state == SAMPLE && state_nx == FIN) begin
      MISMATCH <= |(tt_nx ^ EXPECT);
      ERR_CNT  <= pop;
    end
  end
`else
  logic unused_expect;
  assign unused_expect = ^{EXPECT, start_acc};
  assign MISMATCH = 1'b0;
  assign ERR_CNT  = '0;
`endif
endmodule

// File: tb/tb_comb_scan_ctrl.sv
// tb_comb_scan_ctrl: directed checks of comb_scan_ctrl at defaults and at N_IN=2, SETTLE_CYC=1
module tb_comb_scan_ctrl;
`ifdef COMB_SCAN_CMP_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, start, abort, start2;
  logic [7:0] expect1;
  logic [3:0] expect2;
  logic [2:0] vec;
  logic [1:0] vec2;
  logic busy, done, mm, busy2, done2, mm2;
  logic [7:0] tt;
  logic [3:0] tt2, err;
  logic [2:0] err2;
  logic fsel;
  logic y, y2;
  int total = 0;
  int bad = 0;
  int n;
  bit pulsed;
  always #5 clk = ~clk;
  assign y  = fsel ? ^vec : ((vec[2] & vec[1]) | vec[0]);
  assign y2 = vec2[1] & vec2[0];
  comb_scan_ctrl dut (
    .CLK(clk), .RST(rst), .START(start), .ABORT(abort), .Y_IN(y), .EXPECT(expect1),
    .VEC(vec), .BUSY(busy), .DONE(done), .TT(tt), .MISMATCH(mm), .ERR_CNT(err)
  );
  comb_scan_ctrl #(.N_IN(2), .SETTLE_CYC(1)) dut2 (
    .CLK(clk), .RST(rst), .START(start2), .ABORT(1'b0), .Y_IN(y2), .EXPECT(expect2),
    .VEC(vec2), .BUSY(busy2), .DONE(done2), .TT(tt2), .MISMATCH(mm2), .ERR_CNT(err2)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_vec(input logic [2:0] v);
    int k = 0;
    while (vec !== v && k < 100) begin
      tick;
      k++;
    end
    chk("wait_vec", 32'(vec === v), 32'd1);
  endtask
  task automatic scan(output int lat);
    start = 1'b1;
    tick;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      tick;
      lat++;
    end
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; start2 = 1'b0;
    expect1 = 8'hEA; expect2 = 4'b1000; fsel = 1'b0;
    tick; tick;
    rst = 1'b0;
    chk("rst_vec", 32'(vec), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_tt", 32'(tt), 0);
    chk("rst_mm", 32'(mm), 0);
    chk("rst_err", 32'(err), 0);
    scan(n);
    chk("and_or_lat", n, 24);
    chk("and_or_tt", 32'(tt), 32'hEA);
    chk("and_or_mm", 32'(mm), 0);
    chk("and_or_err", 32'(err), 0);
    chk("fin_vec", 32'(vec), 7);
    tick;
    chk("post_done", 32'(done), 0);
    chk("post_busy", 32'(busy), 0);
    chk("post_vec", 32'(vec), 0);
    fsel = 1'b1; expect1 = 8'h96;
    scan(n);
    chk("xor_lat", n, 24);
    chk("xor_tt", 32'(tt), 32'h96);
    chk("xor_mm", 32'(mm), 0);
    tick;
    expect1 = 8'h97;
    scan(n);
    chk("xor97_tt", 32'(tt), 32'h96);
    chk("xor97_mm", 32'(mm), CMP ? 1 : 0);
    chk("xor97_err", 32'(err), CMP ? 1 : 0);
    repeat (4) tick;
    chk("hold_tt", 32'(tt), 32'h96);
    chk("hold_mm", 32'(mm), CMP ? 1 : 0);
    chk("hold_err", 32'(err), CMP ? 1 : 0);
    fsel = 1'b0; expect1 = 8'hEA;
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_vec(3'd3);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_vec", 32'(vec), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_tt", 32'(tt), 32'h02);
    n = 0;
    repeat (30) begin
      tick;
      n += int'(done);
    end
    chk("abort_no_done", n, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_vec(3'd5);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_rst_vec", 32'(vec), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_tt", 32'(tt), 0);
    chk("mid_rst_mm", 32'(mm), 0);
    chk("mid_rst_err", 32'(err), 0);
    scan(n);
    chk("fresh_lat", n, 24);
    chk("fresh_tt", 32'(tt), 32'hEA);
    tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    n = 0;
    pulsed = 1'b0;
    while (!done && n < 100) begin
      if (vec == 3'd2 && !pulsed) begin
        start = 1'b1;
        pulsed = 1'b1;
      end else start = 1'b0;
      tick;
      n++;
    end
    start = 1'b0;
    chk("restart_lat", n, 24);
    chk("restart_tt", 32'(tt), 32'hEA);
    tick;
    chk("restart_done_once", 32'(done), 0);
    chk("restart_not_queued", 32'(busy), 0);
    abort = 1'b1; start = 1'b1;
    tick;
    abort = 1'b0; start = 1'b0;
    chk("abort_start_busy", 32'(busy), 0);
    chk("abort_start_vec", 32'(vec), 0);
    tick;
    chk("abort_start_idle", 32'(busy), 0);
    start2 = 1'b1;
    tick;
    start2 = 1'b0;
    chk("n2_vec0", 32'(vec2), 0);
    n = 0;
    while (!done2 && n < 50) begin
      tick;
      n++;
      if (!done2) chk("n2_vec_seq", 32'(vec2), 32'(n / 2));
    end
    chk("n2_lat", n, 8);
    chk("n2_tt", 32'(tt2), 32'h8);
    chk("n2_mm", 32'(mm2), 0);
    tick;
    chk("n2_idle", 32'(busy2), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
